// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch stage's external buses: the imem address/data pair, the
//   redirect input from execute, the decode-side valid/ready head interface,
//   the performance counters and a debug view of the fetch FSM.
//
//   Handshake: a decode transfer happens on a rising edge where if_valid and
//   if_ready are both 1 and redirect_valid is 0. While if_valid=1 and
//   if_ready=0, all if_* fields are held stable. A redirect in the same cycle
//   overrides the transfer and decode must drop that head.
//
//   Modports
//     master : the fetch unit (drives imem_addr, if_*, perf_*, dbg_halted)
//     slave  : the environment (drives imem_inst, redirect_*, if_ready)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        if_misalign;
  logic        if_fault;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;
  logic        dbg_halted;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_pc4,
    output if_inst,
    output if_misalign,
    output if_fault,
    output perf_fetched,
    output perf_stalls,
    output perf_flushes,
    output dbg_halted
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_pc4,
    input  if_inst,
    input  if_misalign,
    input  if_fault,
    input  perf_fetched,
    input  perf_stalls,
    input  perf_flushes,
    input  dbg_halted
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the PC, presents it as the imem address,
//   captures the returned word into a small circular fetch buffer and offers
//   the oldest entry {pc, pc+4, inst, misalign, fault} to decode.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : synchronous active-low reset
//     bus    : fetch_unit_if.master (imem, redirect, decode head, perf, debug)
//
//   Parameters
//     RESET_PC   : PC loaded on reset
//     IMEM_WORDS : imem depth in words; byte addresses >= IMEM_WORDS*4 fault
//     BUF_DEPTH  : fetch buffer entries (power of 2, >= 2)
//
//   Build option
//     FETCH_PERF_EN : when defined, perf_fetched/perf_stalls/perf_flushes are
//                     live 32-bit wrapping counters; otherwise they read 0.
//
//   FSM: RUN fetches; HALT is entered after a misaligned or out-of-range
//   entry has been pushed and is left only by a redirect or reset. The state
//   is visible on bus.dbg_halted.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 2048,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int          PW         = $clog2(BUF_DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [63:0] IMEM_BYTES = 64'(IMEM_WORDS) * 64'd4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [31:0]     buf_pc_q   [BUF_DEPTH];
  logic [31:0]     buf_pc4_q  [BUF_DEPTH];
  logic [31:0]     buf_inst_q [BUF_DEPTH];
  logic            buf_mis_q  [BUF_DEPTH];
  logic            buf_flt_q  [BUF_DEPTH];

  logic            run;
  logic            full;
  logic            pop;
  logic            pop_eff;
  logic            push;
  logic            fetch_mis;
  logic            fetch_flt;
  logic            fetch_bad;

  // ---------------------------------------------------------------------------
  // Fetch/handshake decode
  // ---------------------------------------------------------------------------
  assign full      = (count_q == CW'(BUF_DEPTH));
  assign pop       = (count_q != '0) && bus.if_ready;
  // A redirect discards the head, so a same-cycle pop does not advance anything.
  assign pop_eff   = pop && !bus.redirect_valid;
  assign fetch_mis = (pc_q[1:0] != 2'b00);
  assign fetch_flt = ({32'd0, pc_q} >= IMEM_BYTES);
  assign fetch_bad = fetch_mis || fetch_flt;
  // A full buffer can still accept a new word when its head leaves this edge.
  assign push      = run && !bus.redirect_valid && (!full || pop);

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid)      state_d = ST_RUN;
    else if (push && fetch_bad)  state_d = ST_HALT;
  end

  always_comb begin
    run            = (state_q == ST_RUN);
    bus.dbg_halted = (state_q == ST_HALT);
  end

  // ---------------------------------------------------------------------------
  // PC, occupancy and pointers
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      // A bad fetch parks the PC on the offending address.
      if (push && !fetch_bad) pc_d = pc_q + 32'd4;
      if (push)    wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_eff) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop_eff})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch buffer storage. Cleared on reset so the head fields read 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_pc4_q[i]  <= '0;
        buf_inst_q[i] <= '0;
        buf_mis_q[i]  <= 1'b0;
        buf_flt_q[i]  <= 1'b0;
      end
    end else if (push) begin
      buf_pc_q[wr_ptr_q]   <= pc_q;
      buf_pc4_q[wr_ptr_q]  <= pc_q + 32'd4;
      buf_inst_q[wr_ptr_q] <= fetch_bad ? NOP_INST : bus.imem_inst;
      buf_mis_q[wr_ptr_q]  <= fetch_mis;
      buf_flt_q[wr_ptr_q]  <= fetch_flt;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = (count_q != '0);
  assign bus.if_pc       = buf_pc_q[rd_ptr_q];
  assign bus.if_pc4      = buf_pc4_q[rd_ptr_q];
  assign bus.if_inst     = buf_inst_q[rd_ptr_q];
  assign bus.if_misalign = buf_mis_q[rd_ptr_q];
  assign bus.if_fault    = buf_flt_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stalls_q;
  logic [31:0] perf_flushes_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (push)                          perf_fetched_q <= perf_fetched_q + 32'd1;
      if (bus.if_valid && !bus.if_ready) perf_stalls_q  <= perf_stalls_q + 32'd1;
      if (bus.redirect_valid)            perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stalls  = perf_stalls_q;
  assign bus.perf_flushes = perf_flushes_q;
`else
  assign bus.perf_fetched = 32'h0;
  assign bus.perf_stalls  = 32'h0;
  assign bus.perf_flushes = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit with IMEM_WORDS=2048, BUF_DEPTH=2, RESET_PC=0.
//   imem is modelled as imem[k]=k. Each redirect/reset loads the expected
//   instruction stream into exp_q; the monitor compares the buffer head with
//   the queue front every valid cycle and pops on an accepted transfer.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  localparam int IMEM_WORDS = 2048;
  localparam int EW         = 98;  // {pc, pc4, inst, mis, flt}

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (IMEM_WORDS),
    .BUF_DEPTH  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // imem[k] = k, combinational read
  assign bus.imem_inst = {2'b00, bus.imem_addr[31:2]};

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_entry(input logic [31:0] pc);
    logic        mis;
    logic        flt;
    logic [31:0] inst;
    mis  = (pc[1:0] != 2'b00);
    flt  = (pc >= 32'(IMEM_WORDS * 4));
    inst = (mis || flt) ? 32'h0000_0013 : {2'b00, pc[31:2]};
    return {pc, pc + 32'd4, inst, mis, flt};
  endfunction

  // Expected stream from a start address: sequential words, ending with the
  // first misaligned/faulting entry (fetch halts after it).
  task automatic load_stream(input logic [31:0] start);
    logic [31:0]   pc;
    logic [EW-1:0] e;
    pc = start;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      e = mk_entry(pc);
      exp_q.push_back(e);
      if (e[1] || e[0]) break;
      pc = pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !bus.redirect_valid && bus.if_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", EW'(exp_q.size()), EW'(1));
      end else begin
        check_eq("head", {bus.if_pc, bus.if_pc4, bus.if_inst, bus.if_misalign, bus.if_fault},
                 exp_q[0]);
        if (bus.if_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    load_stream(target);
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic check_perf(input string tag, input logic [31:0] f, input logic [31:0] s,
                            input logic [31:0] r);
`ifdef FETCH_PERF_EN
    check_eq({tag, "_fetched"}, EW'(bus.perf_fetched), EW'(f));
    check_eq({tag, "_stalls"},  EW'(bus.perf_stalls),  EW'(s));
    check_eq({tag, "_flushes"}, EW'(bus.perf_flushes), EW'(r));
`else
    check_eq({tag, "_fetched"}, EW'(bus.perf_fetched), EW'(0));
    check_eq({tag, "_stalls"},  EW'(bus.perf_stalls),  EW'(0));
    check_eq({tag, "_flushes"}, EW'(bus.perf_flushes), EW'(0));
`endif
  endtask

  task automatic check_halted_at(input string tag, input logic [31:0] addr);
    @(negedge clk);
    check_eq({tag, "_valid"},  EW'(bus.if_valid),   EW'(0));
    check_eq({tag, "_addr"},   EW'(bus.imem_addr),  EW'(addr));
    check_eq({tag, "_halted"}, EW'(bus.dbg_halted), EW'(1));
    check_eq({tag, "_drain"},  EW'(exp_q.size()),   EW'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] tgt;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst_n              = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_valid", EW'(bus.if_valid), EW'(0));
    check_eq("rst_head", {bus.if_pc, bus.if_pc4, bus.if_inst, bus.if_misalign, bus.if_fault},
             EW'(0));
    check_eq("rst_addr",   EW'(bus.imem_addr),  EW'(0));
    check_eq("rst_halted", EW'(bus.dbg_halted), EW'(0));
    check_perf("rst_perf", 32'd0, 32'd0, 32'd0);

    // Release: 1-cycle latency, stream 0,4,8,.. then 3 stall cycles
    tick();
    rst_n = 1'b1;
    load_stream(32'h0);
    for (int k = 1; k <= 12; k++) begin
      bus.if_ready = (k >= 5 && k <= 7) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k == 1) check_eq("lat_c0_valid", EW'(bus.if_valid), EW'(0));
      if (k == 2) begin
        check_eq("lat_c1_valid", EW'(bus.if_valid), EW'(1));
        check_eq("lat_c1_pc",    EW'(bus.if_pc),    EW'(32'h0));
      end
      if (k == 5) check_eq("pre_stall_addr", EW'(bus.imem_addr), EW'(32'h10));
      if (k == 6 || k == 7) begin
        check_eq("stall_pc",   EW'(bus.if_pc),     EW'(32'hC));
        check_eq("stall_inst", EW'(bus.if_inst),   EW'(32'h3));
        check_eq("stall_addr", EW'(bus.imem_addr), EW'(32'h14));
      end
      tick();
    end

    // Redirect while full with if_ready=1
    do_redirect(32'h100);
    @(negedge clk);
    check_eq("redir_flush_valid", EW'(bus.if_valid), EW'(0));
    check_perf("perf", 32'd10, 32'd3, 32'd1);
    tick();
    @(negedge clk);
    check_eq("redir_first_valid", EW'(bus.if_valid), EW'(1));
    check_eq("redir_first_pc",    EW'(bus.if_pc),    EW'(32'h100));
    repeat (3) tick();

    // Misaligned target
    do_redirect(32'h102);
    repeat (8) tick();
    check_halted_at("mis", 32'h102);

    // Out-of-range target, then both flags at once
    tick();
    do_redirect(32'h2000);
    repeat (8) tick();
    check_halted_at("flt", 32'h2000);
    tick();
    do_redirect(32'h2002);
    repeat (8) tick();
    check_halted_at("misflt", 32'h2002);

    // Resume from halt
    tick();
    do_redirect(32'h0);
    repeat (5) tick();
    @(negedge clk);
    check_eq("resume_halted", EW'(bus.dbg_halted), EW'(0));
    check_eq("resume_valid",  EW'(bus.if_valid),   EW'(1));

    // Back-to-back redirects: last wins
    tick();
    do_redirect(32'h200);
    do_redirect(32'h300);
    @(negedge clk);
    check_eq("b2b_valid0", EW'(bus.if_valid), EW'(0));
    tick();
    @(negedge clk);
    check_eq("b2b_pc", EW'(bus.if_pc), EW'(32'h300));

    // Redirect then hold if_ready=0 for 5 cycles: two entries, pc parks at 8
    tick();
    bus.if_ready = 1'b0;
    do_redirect(32'h0);
    repeat (5) tick();
    @(negedge clk);
    check_eq("hold_addr", EW'(bus.imem_addr), EW'(32'h8));
    check_eq("hold_pc",   EW'(bus.if_pc),     EW'(32'h0));
    tick();
    bus.if_ready = 1'b1;
    repeat (6) tick();

    // Random ready / redirect traffic
    for (int i = 0; i < 400; i++) begin
      bus.if_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        tgt = 32'($urandom_range(0, IMEM_WORDS - 1)) << 2;
        case ($urandom_range(0, 7))
          0:       tgt = tgt + 32'd2;
          1:       tgt = 32'h2000 + tgt;
          default: tgt = tgt;
        endcase
        do_redirect(tgt);
      end else begin
        tick();
      end
    end

    // Reset in the middle of traffic
    bus.if_ready = 1'b0;
    do_redirect(32'h40);
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_eq("midrst_valid", EW'(bus.if_valid),  EW'(0));
    check_eq("midrst_addr",  EW'(bus.imem_addr), EW'(0));
    check_perf("midrst_perf", 32'd0, 32'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.if_ready = 1'b1;
    load_stream(32'h0);
    repeat (4) tick();
    @(negedge clk);
    check_eq("postrst_valid", EW'(bus.if_valid), EW'(1));
    check_eq("postrst_pc",    EW'(bus.if_pc),    EW'(32'hC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
